curve_lut_stream: RTL and testbench



---
 rtl/curve_lut_stream.sv | 138 +++++++++++++
 tb/tb_curve_lut_stream.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/curve_lut_stream.sv
// Double-buffered per-channel tone-curve LUT on a pixel stream; the shadow bank goes live at a frame start.
// Latency 2 clk for data and syncs; no backpressure, so the stream is qualified downstream by clken.
module curve_lut_stream #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       per_frame_vsync,
  input  logic                       per_frame_href,
  input  logic                       per_frame_clken,
  input  logic [CHANNELS*DATA_W-1:0] per_img_data,
  input  logic                       bypass,
  input  logic                       lut_wr_en,
  input  logic [DATA_W-1:0]          lut_wr_addr,
  input  logic [DATA_W-1:0]          lut_wr_data,
  input  logic                       lut_commit,
  output logic                       lut_ready,
  output logic                       commit_pending,
  output logic                       post_frame_vsync,
  output logic                       post_frame_href,
  output logic                       post_frame_clken,
  output logic [CHANNELS*DATA_W-1:0] post_img_data
);

  localparam int DEPTH = 1 << DATA_W;
  localparam int PW    = CHANNELS * DATA_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] init_addr_q, init_addr_d;
  logic              bank_sel_q, bank_sel_d;
  logic              pending_q, pending_d;

  logic [DATA_W-1:0] bank_a [DEPTH];
  logic [DATA_W-1:0] bank_b [DEPTH];

  logic          vs_s1_q, hr_s1_q, ck_s1_q, byp_s1_q;
  logic [PW-1:0] pix_s1_q;
  logic          vs_s2_q, hr_s2_q, ck_s2_q;
  logic [PW-1:0] pix_s2_q;
  logic [PW-1:0] mapped;
  logic          vsync_rise;

  // Stage-1 vsync doubles as the delayed copy for edge detection.
  assign vsync_rise = per_frame_vsync & ~vs_s1_q;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    bank_sel_d  = bank_sel_q;
    pending_d   = pending_q;
    case (state_q)
      S_INIT: begin
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        if (vsync_rise && (pending_q || lut_commit)) begin
          bank_sel_d = ~bank_sel_q;
          pending_d  = 1'b0;
        end else if (lut_commit) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      init_addr_q <= '0;
      bank_sel_q  <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      bank_sel_q  <= bank_sel_d;
      pending_q   <= pending_d;
    end
  end

  // Banks hold no reset; INIT rewrites both with identity. Run-time writes hit the shadow only.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      bank_a[init_addr_q] <= init_addr_q;
      bank_b[init_addr_q] <= init_addr_q;
    end else if (lut_wr_en) begin
      if (bank_sel_q) bank_a[lut_wr_addr] <= lut_wr_data;
      else            bank_b[lut_wr_addr] <= lut_wr_data;
    end
  end

  always_comb begin
    logic [DATA_W-1:0] in_c;
    mapped = '0;
    in_c   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      in_c = pix_s1_q[c*DATA_W +: DATA_W];
      mapped[c*DATA_W +: DATA_W] = byp_s1_q   ? in_c :
                                   bank_sel_q ? bank_b[in_c] : bank_a[in_c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1_q  <= 1'b0;
      hr_s1_q  <= 1'b0;
      ck_s1_q  <= 1'b0;
      byp_s1_q <= 1'b0;
      pix_s1_q <= '0;
      vs_s2_q  <= 1'b0;
      hr_s2_q  <= 1'b0;
      ck_s2_q  <= 1'b0;
      pix_s2_q <= '0;
    end else begin
      vs_s1_q  <= per_frame_vsync;
      hr_s1_q  <= per_frame_href;
      ck_s1_q  <= per_frame_clken;
      byp_s1_q <= bypass | (state_q == S_INIT);
      pix_s1_q <= per_img_data;
      vs_s2_q  <= vs_s1_q;
      hr_s2_q  <= hr_s1_q;
      ck_s2_q  <= ck_s1_q;
      pix_s2_q <= mapped;
    end
  end

  assign lut_ready        = (state_q == S_RUN);
  assign commit_pending   = pending_q;
  assign post_frame_vsync = vs_s2_q;
  assign post_frame_href  = hr_s2_q;
  assign post_frame_clken = ck_s2_q;
  assign post_img_data    = pix_s2_q;

endmodule

// File: tb/tb_curve_lut_stream.sv
// Bench for curve_lut_stream: hand sequences, a vector table and random traffic against a curve-array model.
module tb_curve_lut_stream;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int PW = DW * CH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
  logic [PW-1:0] per_img_data = '0;
  logic          bypass = 1'b0;
  logic          lut_wr_en = 1'b0;
  logic [DW-1:0] lut_wr_addr = '0, lut_wr_data = '0;
  logic          lut_commit = 1'b0;
  logic          lut_ready, commit_pending;
  logic          post_frame_vsync, post_frame_href, post_frame_clken;
  logic [PW-1:0] post_img_data;

  curve_lut_stream #(.DATA_W(DW), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_data(per_img_data),
    .bypass(bypass), .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr),
    .lut_wr_data(lut_wr_data), .lut_commit(lut_commit),
    .lut_ready(lut_ready), .commit_pending(commit_pending),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_data(post_img_data)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: two curves as plain arrays, an active index, a pending flag and a 2-deep output delay.
  typedef struct packed {
    logic          vs;
    logic          hr;
    logic          ck;
    logic [PW-1:0] d;
  } item_t;

  bit            m_ready, m_pend, m_sel, m_vs_prev;
  int            m_cnt;
  logic [DW-1:0] m_curve [2][256];
  item_t         m_next, m_exp;

  task automatic model_reset();
    m_ready = 0; m_pend = 0; m_sel = 0; m_vs_prev = 0; m_cnt = 0;
    m_next = '0; m_exp = '0;
  endtask

  task automatic model_step();
    bit    rise, use_byp;
    item_t it;
    rise    = per_frame_vsync && !m_vs_prev;
    use_byp = bypass || !m_ready;
    if (m_ready) begin
      if (lut_wr_en) m_curve[m_sel ? 0 : 1][lut_wr_addr] = lut_wr_data;
      if (rise && (m_pend || lut_commit)) begin
        m_sel  = !m_sel;
        m_pend = 0;
      end else if (lut_commit) begin
        m_pend = 1;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 256) begin
        m_ready = 1;
        for (int i = 0; i < 256; i++) begin
          m_curve[0][i] = 8'(i);
          m_curve[1][i] = 8'(i);
        end
      end
    end
    it.vs = per_frame_vsync;
    it.hr = per_frame_href;
    it.ck = per_frame_clken;
    for (int c = 0; c < CH; c++)
      it.d[c*DW +: DW] = use_byp ? per_img_data[c*DW +: DW]
                                 : m_curve[m_sel][per_img_data[c*DW +: DW]];
    m_exp     = m_next;
    m_next    = it;
    m_vs_prev = per_frame_vsync;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    chk("model_sync", 32'({post_frame_vsync, post_frame_href, post_frame_clken}),
        32'({m_exp.vs, m_exp.hr, m_exp.ck}));
    chk("model_data", 32'(post_img_data), 32'(m_exp.d));
    chk("model_status", 32'({lut_ready, commit_pending}), 32'({m_ready, m_pend}));
  end

  // One input cycle: drive at a falling edge, return at the next falling edge.
  task automatic cyc(input logic vs, input logic hr, input logic ck, input logic [PW-1:0] d,
                     input logic byp, input logic we = 1'b0, input logic [DW-1:0] wa = '0,
                     input logic [DW-1:0] wd = '0, input logic cm = 1'b0);
    per_frame_vsync = vs; per_frame_href = hr; per_frame_clken = ck;
    per_img_data = d; bypass = byp;
    lut_wr_en = we; lut_wr_addr = wa; lut_wr_data = wd; lut_commit = cm;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic px(input logic [PW-1:0] d, input logic byp);
    cyc(1'b0, 1'b1, 1'b1, d, byp);
  endtask

  task automatic vsync_pulse(input logic cm = 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, cm);
    idle();
  endtask

  task automatic load_curve(input bit inverse);
    for (int i = 0; i < 256; i++)
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 8'(i), inverse ? 8'(255 - i) : 8'(i));
  endtask

  // Pixel out two cycles after it goes in.
  task automatic map_px(input string name, input logic [PW-1:0] d, input logic byp,
                        input logic [PW-1:0] exp);
    px(d, byp);
    idle();
    chk(name, 32'(post_img_data), 32'(exp));
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!lut_ready && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [PW-1:0] d;
    logic          byp;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t vecs [7];
  int   n_wait;

  initial begin
    vecs[0] = '{24'h202020, 1'b0, 24'hDFDFDF};
    vecs[1] = '{24'h202020, 1'b1, 24'h202020};
    vecs[2] = '{24'h000000, 1'b0, 24'hFFFFFF};
    vecs[3] = '{24'hFFFFFF, 1'b0, 24'h000000};
    vecs[4] = '{24'h01807F, 1'b0, 24'hFE7F80};
    vecs[5] = '{24'h123456, 1'b1, 24'h123456};
    vecs[6] = '{24'h10EF00, 1'b0, 24'hEF10FF};

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(lut_ready), 0);
    chk("rst_pending", 32'(commit_pending), 0);
    chk("rst_outputs", 32'({post_frame_vsync, post_frame_href, post_frame_clken, post_img_data}), 0);

    rst_n = 1'b1;
    wait_ready(n_wait);
    chk("init_length", 32'(n_wait), 256);

    cyc(1'b1, 1'b1, 1'b1, 24'h4080C0, 1'b0);
    chk("latency_not_early", 32'({post_frame_vsync, post_frame_href, post_frame_clken}), 0);
    idle();
    chk("identity_data", 32'(post_img_data), 32'h4080C0);
    chk("identity_syncs", 32'({post_frame_vsync, post_frame_href, post_frame_clken}), 32'h7);

    // Inverse curve committed mid-frame; current frame keeps identity.
    vsync_pulse();
    load_curve(1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("pending_set", 32'(commit_pending), 1);
    map_px("same_frame_identity", 24'h101010, 1'b0, 24'h101010);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("pending_cleared", 32'(commit_pending), 0);
    idle();
    map_px("next_frame_inverse", 24'h101010, 1'b0, 24'hEFEFEF);

    // Commit on the vsync edge itself.
    load_curve(1'b1);
    chk("pending_before_edge", 32'(commit_pending), 0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("pending_on_edge_commit", 32'(commit_pending), 0);
    idle();
    map_px("edge_commit_inverse", 24'h000000, 1'b0, 24'hFFFFFF);

    for (int i = 0; i <= 7; i++) begin
      if (i < 7) px(vecs[i].d, vecs[i].byp);
      else       idle();
      if (i > 0) chk($sformatf("vec%0d", i - 1), 32'(post_img_data), 32'(vecs[i-1].exp));
    end

    // Shadow writes without commit stay invisible across a vsync edge.
    load_curve(1'b0);
    vsync_pulse();
    map_px("uncommitted_invisible", 24'h101010, 1'b0, 24'hEFEFEF);

    // Two commits then one edge: a single swap, to the identity shadow.
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("double_commit_pending", 32'(commit_pending), 1);
    vsync_pulse();
    map_px("double_commit_one_swap", 24'h101010, 1'b0, 24'h101010);

    // Write landing in the swap cycle joins the newly active curve.
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 8'h33, 8'h55);
    idle();
    map_px("swap_cycle_write", 24'h333333, 1'b0, 24'h555555);
    map_px("swap_back_inverse", 24'h101010, 1'b0, 24'hEFEFEF);

    // Reset mid-frame, then writes and commits during INIT.
    px(24'h505050, 1'b0);
    px(24'h505050, 1'b0);
    chk("pre_reset_output", 32'(post_img_data), 32'hAFAFAF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        32'({post_frame_vsync, post_frame_href, post_frame_clken, post_img_data}), 0);
    chk("async_reset_status", 32'({lut_ready, commit_pending}), 0);
    @(negedge clk);
    per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_data = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++)
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 8'(i), 8'hAA, (i % 10) == 0);
    chk("init_commit_ignored", 32'(commit_pending), 0);
    wait_ready(n_wait);
    chk("reinit_remaining", 32'(n_wait), 206);
    vsync_pulse();
    chk("pending_after_init", 32'(commit_pending), 0);
    map_px("identity_after_reinit", 24'h102030, 1'b0, 24'h102030);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      logic vs, hr;
      vs = (i % 250) < 3;
      hr = ((i % 250) > 8) && ($urandom_range(0, 9) != 0);
      cyc(vs, hr, hr && $urandom_range(0, 3) != 0, PW'($urandom), $urandom_range(0, 7) == 0,
          $urandom_range(0, 2) == 0, DW'($urandom), DW'($urandom),
          (i % 250 == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 99) == 0));
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
